// File: rtl/mem_types_pkg.sv
// Shared memory-subsystem types: RAM word, RAM handshake state and arbiter FSM state.
package mem_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port RAM between instruction and data sides, moving one
// BLOCK_WORDS burst per grant; data side wins unless the instruction side is starved.
module mem_arbiter
  import mem_types_pkg::*;
#(
  parameter int BLOCK_WORDS = 2,
  parameter int STARVE_MAX  = 4,
  localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  word_t         iaddr,
  output word_t         iload,
  output logic          ivalid,
  output logic [IW-1:0] iidx,
  output logic          idone,
  input  logic          dREN,
  input  logic          dWEN,
  input  word_t         daddr,
  input  word_t         dstore,
  output word_t         dload,
  output logic          dvalid,
  output logic [IW-1:0] didx,
  output logic          ddone,
  output logic          ramREN,
  output logic          ramWEN,
  output word_t         ramaddr,
  output word_t         ramstore,
  input  word_t         ramload,
  input  ramstate_t     ramstate,
  output arb_state_t    arb_state,
  output logic [SW-1:0] starve_count
);

  localparam int BASEW = 32 - IW - 2;

  arb_state_t       state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [SW-1:0]    starve, starve_n;
  logic             op_write, op_write_n;
  logic [BASEW-1:0] op_base, op_base_n;
  logic             d_req, last, acc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      idx      <= '0;
      starve   <= '0;
      op_write <= 1'b0;
      op_base  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      starve   <= starve_n;
      op_write <= op_write_n;
      op_base  <= op_base_n;
    end
  end

  // Handshake: a requester holds xREN/dWEN until xdone; each cycle with
  // xvalid=1 one word of its block completes (no ready, the RAM paces it).
  // Dropping the request mid-burst abandons the rest of the block.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    starve_n   = starve;
    op_write_n = op_write;
    op_base_n  = op_base;
    d_req      = dREN | dWEN;
    last       = (idx == IW'(BLOCK_WORDS - 1));
    acc        = (ramstate == ACCESS);

    case (state)
      IDLE: begin
        if (iREN && (!d_req || starve == SW'(STARVE_MAX))) begin
          state_n    = I_XFER;
          idx_n      = '0;
          starve_n   = '0;
          op_write_n = 1'b0;
          op_base_n  = iaddr[31:IW+2];
        end else if (d_req) begin
          state_n    = D_XFER;
          idx_n      = '0;
          op_write_n = dWEN;
          op_base_n  = daddr[31:IW+2];
          if (iREN && starve != SW'(STARVE_MAX))
            starve_n = starve + 1'b1;
        end
      end
      I_XFER, D_XFER: begin
        if ((state == I_XFER) ? !iREN : !d_req) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (acc) begin
          if (last) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase

    ramREN   = (state != IDLE) && !op_write;
    ramWEN   = (state != IDLE) && op_write;
    ramaddr  = (state != IDLE) ? {op_base, idx, 2'b00} : '0;
    ramstore = (state == D_XFER && op_write) ? dstore : '0;

    ivalid = (state == I_XFER) && acc;
    iload  = ivalid ? ramload : '0;
    iidx   = (state == I_XFER) ? idx : '0;
    idone  = ivalid && last;

    dvalid = (state == D_XFER) && acc;
    dload  = dvalid ? ramload : '0;
    didx   = (state == D_XFER) ? idx : '0;
    ddone  = dvalid && last;

    arb_state    = state;
    starve_count = starve;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-sequence bench for mem_arbiter with a variable-latency RAM model and
// a block-level scoreboard of expected words per side.
module tb_mem_arbiter;
  import mem_types_pkg::*;

  localparam int BW   = 2;
  localparam int SMAX = 4;
  localparam int IW   = 1;
  localparam int SW   = 3;
  localparam int TMO  = 200;
  localparam int EW   = 65 + IW;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            iREN, dREN, dWEN;
  word_t           iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  logic            ivalid, idone, dvalid, ddone, ramREN, ramWEN;
  logic [IW-1:0]   iidx, didx;
  ramstate_t       ramstate;
  arb_state_t      arb_state;
  logic [SW-1:0]   starve_count;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  mem_arbiter #(.BLOCK_WORDS(BW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ivalid(ivalid), .iidx(iidx), .idone(idone),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dvalid(dvalid), .didx(didx), .ddone(ddone),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .arb_state(arb_state), .starve_count(starve_count)
  );

  // ---------------- RAM model ----------------
  // A word is BUSY for its first cycle (address change) and then until it has
  // spent busy_lat BUSY cycles; ERROR cycles inside [err_from, err_to) add delay.
  logic [31:0] init_mem [256];
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wbuf [BW];
  bit          loaded = 1'b0;
  int          busy_lat = 1;
  int          cyc = 0;
  int          err_from = 0;
  int          err_to = 0;
  logic        prev_en, prev_we;
  word_t       prev_addr;
  int          wait_cnt;
  logic        ram_en, new_word, err_now;

  assign ram_en   = ramREN | ramWEN;
  assign new_word = ram_en && (!prev_en || prev_addr != ramaddr || prev_we != ramWEN);
  assign err_now  = (cyc >= err_from) && (cyc < err_to);
  assign ramload  = ram_en ? mem[ramaddr[9:2]] : '0;

  always_comb begin
    ramstate = FREE;
    if (!ram_en) ramstate = FREE;
    else if (err_now) ramstate = ERROR;
    else if (new_word || wait_cnt < busy_lat) ramstate = BUSY;
    else ramstate = ACCESS;
  end

  always_comb dstore = wbuf[didx];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prev_en   <= 1'b0;
      prev_we   <= 1'b0;
      prev_addr <= '0;
      wait_cnt  <= 0;
    end else begin
      prev_en   <= ram_en;
      prev_we   <= ramWEN;
      prev_addr <= ramaddr;
      if (new_word) wait_cnt <= err_now ? 0 : 1;
      else if (ram_en && !err_now && wait_cnt < busy_lat) wait_cnt <= wait_cnt + 1;
    end
  end

  always @(posedge CLK) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_mem[k];
      loaded <= 1'b1;
    end else if (nRST && ramWEN && ramstate == ACCESS) begin
      mem[ramaddr[9:2]] <= ramstore;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {write, idx, word address, data}
  logic [EW-1:0] i_q[$];
  logic [EW-1:0] d_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (ivalid) begin
        check("i_on_access", 32'(ramstate), 32'(ACCESS));
        check("i_side_only", {29'b0, dvalid, ddone, ramWEN}, 32'h0);
        check("i_dload_zero", dload, 32'h0);
        if (i_q.size() == 0) begin
          check("i_unexpected", 32'(ivalid), 32'h0);
        end else begin
          mon_e = i_q.pop_front();
          check("i_idx", 32'(iidx), 32'(mon_e[63+IW:64]));
          check("i_ramaddr", ramaddr, mon_e[63:32]);
          check("i_load", iload, mon_e[31:0]);
        end
      end
      if (dvalid) begin
        check("d_on_access", 32'(ramstate), 32'(ACCESS));
        check("d_side_only", {30'b0, ivalid, idone}, 32'h0);
        check("d_iload_zero", iload, 32'h0);
        if (d_q.size() == 0) begin
          check("d_unexpected", 32'(dvalid), 32'h0);
        end else begin
          mon_e = d_q.pop_front();
          check("d_idx", 32'(didx), 32'(mon_e[63+IW:64]));
          check("d_ramaddr", ramaddr, mon_e[63:32]);
          check("d_ramwen", 32'(ramWEN), 32'(mon_e[64+IW]));
          if (mon_e[64+IW]) check("d_ramstore", ramstore, mon_e[31:0]);
          else              check("d_load", dload, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input bit d, input bit wr, input logic [31:0] base, input int i);
    logic [31:0] blk, a, data;
    blk = base & ~32'(BW * 4 - 1);
    a   = blk + 32'(i * 4);
    if (wr) begin
      data = wbuf[i];
      ref_mem[a[9:2]] = data;
    end else begin
      data = ref_mem[a[9:2]];
    end
    if (d) d_q.push_back({wr, IW'(i), a, data});
    else   i_q.push_back({wr, IW'(i), a, data});
  endtask

  task automatic push_block(input bit d, input bit wr, input logic [31:0] base);
    for (int i = 0; i < BW; i++) push_word(d, wr, base, i);
  endtask

  // Cycle numbers count negedges after the one where the request was raised.
  task automatic wait_side(input bit d, input bit stop_first,
                           output int first_c, output int done_c, output int nv);
    first_c = -1;
    done_c  = -1;
    nv      = 0;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge CLK);
      if (d ? dvalid : ivalid) begin
        nv++;
        if (first_c < 0) first_c = c;
        if (stop_first) return;
        if (d ? ddone : idone) begin
          done_c = c;
          return;
        end
      end
    end
    check("wait_timeout", 32'(done_c), 32'(TMO));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {25'b0, ivalid, idone, dvalid, ddone, ramREN, ramWEN, 1'b0}, 32'h0);
    check({tag, "_idx"}, {30'b0, iidx, didx}, 32'h0);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
    check({tag, "_loads"}, iload | dload, 32'h0);
    check({tag, "_state"}, 32'(arb_state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  int first_c, done_c, nv, exp_starve;
  bit i_wins;

  initial begin
    nRST  = 1'b0;
    iREN  = 1'b1;
    dREN  = 1'b0;
    dWEN  = 1'b1;
    iaddr = 32'h40;
    daddr = 32'h10;
    exp_starve = 0;
    for (int k = 0; k < 256; k++) begin
      init_mem[k] = $urandom;
      ref_mem[k]  = init_mem[k];
    end
    for (int i = 0; i < BW; i++) wbuf[i] = $urandom;

    // reset with requests asserted: everything stays quiet
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    check("reset_starve", 32'(starve_count), 32'h0);
    iREN = 1'b0;
    dWEN = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);

    // I-only block read, base 0x100
    busy_lat = 1;
    iaddr = 32'h104;
    push_block(0, 0, iaddr);
    iREN = 1'b1;
    wait_side(0, 0, first_c, done_c, nv);
    iREN = 1'b0;
    check("t1_first", 32'(first_c), 32'(busy_lat + 1));
    check("t1_done", 32'(done_c), 32'(BW * (busy_lat + 1)));
    check("t1_nvalid", 32'(nv), 32'(BW));

    // simultaneous I read and D write of the same block: D first, then I sees new data
    @(negedge CLK);
    for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
    daddr = 32'h208 | 32'($urandom_range(0, 7));
    iaddr = 32'h20C;
    push_block(1, 1, daddr);
    push_block(0, 0, iaddr);
    iREN = 1'b1;
    dWEN = 1'b1;
    wait_side(1, 0, first_c, done_c, nv);
    dWEN = 1'b0;
    exp_starve = 1;
    check("t2_d_first", 32'(first_c), 32'(busy_lat + 1));
    check("t2_d_done", 32'(done_c), 32'(BW * (busy_lat + 1)));
    check("t2_starve_d", 32'(starve_count), 32'(exp_starve));
    wait_side(0, 0, first_c, done_c, nv);
    iREN = 1'b0;
    exp_starve = 0;
    check("t2_i_first", 32'(first_c), 32'(busy_lat + 2));
    check("t2_i_nvalid", 32'(nv), 32'(BW));
    check("t2_starve_i", 32'(starve_count), 32'(exp_starve));

    // starvation: I held, D re-requests every time it returns to idle
    iaddr = 32'h300;
    iREN  = 1'b1;
    for (int g = 0; g < SMAX + 1; g++) begin
      @(negedge CLK);
      daddr = 32'h400 + 32'(g * 8) + 32'($urandom_range(0, 7));
      dREN  = 1'b1;
      i_wins = (exp_starve == SMAX);
      if (i_wins) begin
        push_block(0, 0, iaddr);
        wait_side(0, 0, first_c, done_c, nv);
        iREN = 1'b0;
        dREN = 1'b0;
        exp_starve = 0;
        check("t3_i_nvalid", 32'(nv), 32'(BW));
        check("t3_starve_clr", 32'(starve_count), 32'(exp_starve));
      end else begin
        push_block(1, 0, daddr);
        wait_side(1, 0, first_c, done_c, nv);
        dREN = 1'b0;
        exp_starve = (exp_starve < SMAX) ? exp_starve + 1 : SMAX;
        check("t3_d_first", 32'(first_c), 32'(busy_lat + 1));
        check("t3_starve", 32'(starve_count), 32'(exp_starve));
      end
    end

    // slower RAM: three BUSY cycles per word
    @(negedge CLK);
    busy_lat = 3;
    iaddr = 32'h500 | 32'($urandom_range(0, 7));
    push_block(0, 0, iaddr);
    iREN = 1'b1;
    wait_side(0, 0, first_c, done_c, nv);
    iREN = 1'b0;
    check("t4_first", 32'(first_c), 32'(busy_lat + 1));
    check("t4_done", 32'(done_c), 32'(BW * (busy_lat + 1)));

    // two ERROR cycles in the middle of word 0 stretch the burst by two
    @(negedge CLK);
    err_from = cyc + 2;
    err_to   = cyc + 4;
    daddr = 32'h600;
    push_block(1, 0, daddr);
    dREN = 1'b1;
    wait_side(1, 0, first_c, done_c, nv);
    dREN = 1'b0;
    err_to = 0;
    check("t4_err_first", 32'(first_c), 32'(busy_lat + 3));
    check("t4_err_done", 32'(done_c), 32'(BW * (busy_lat + 1) + 2));
    check("t4_err_nvalid", 32'(nv), 32'(BW));

    // abort: D drops its request after word 0; I follows normally
    @(negedge CLK);
    busy_lat = 1;
    daddr = 32'h700;
    push_word(1, 0, daddr, 0);
    dREN = 1'b1;
    wait_side(1, 1, first_c, done_c, nv);
    check("t5_word0", 32'(first_c), 32'(busy_lat + 1));
    dREN  = 1'b0;
    iaddr = 32'h720;
    push_block(0, 0, iaddr);
    iREN = 1'b1;
    @(negedge CLK);
    check("t5_idle", 32'(arb_state), 32'(IDLE));
    check("t5_no_ddone", {30'b0, ddone, dvalid}, 32'h0);
    wait_side(0, 0, first_c, done_c, nv);
    iREN = 1'b0;
    check("t5_i_first", 32'(first_c), 32'(busy_lat + 1));
    check("t5_i_done", 32'(done_c), 32'(BW * (busy_lat + 1)));

    // reset mid-burst with the request still held
    @(negedge CLK);
    iaddr = 32'h800;
    push_block(0, 0, iaddr);
    iREN = 1'b1;
    wait_side(0, 1, first_c, done_c, nv);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_starve", 32'(starve_count), 32'h0);
    i_q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    push_block(0, 0, iaddr);
    wait_side(0, 0, first_c, done_c, nv);
    iREN = 1'b0;
    check("t6_first", 32'(first_c), 32'(busy_lat + 1));
    check("t6_done", 32'(done_c), 32'(BW * (busy_lat + 1)));
    check("t6_nvalid", 32'(nv), 32'(BW));

    @(negedge CLK);
    check("queues_empty", 32'(i_q.size() + d_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
